// File: rtl/vga_fb_reader_if.sv
// Framebuffer read bus between the pixel-fetch stage (master) and its
// synchronous RAM (slave).
interface vga_fb_reader_if #(
  parameter int ADDR_BIT = 15,
  parameter int DATA_BIT = 8
);
  logic [ADDR_BIT-1:0] rd_addr;
  logic                rd_en;
  logic [DATA_BIT-1:0] rd_data;

  modport master (output rd_addr, output rd_en, input rd_data);
  modport slave  (input rd_addr, input rd_en, output rd_data);
endinterface

// File: rtl/vga_fb_reader.sv
// VGA pixel-fetch stage: maps the screen coordinate to a scaled framebuffer
// address, reads the pixel and drives colour and sync pins aligned together.
module vga_fb_reader #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int SCALE_SHIFT = 2,
  parameter int ADDR_BIT    = 15,
  parameter int DATA_BIT    = 8,
  parameter int RD_LATENCY  = 1,
  parameter int PX_PERIOD   = 4
) (
  input  logic                clk,
  input  logic                i_sclr,
  input  logic                i_px_clk,
  input  logic                i_hsync_enb,
  input  logic                i_vsync_enb,
  input  logic                i_h_addr_enb,
  input  logic                i_v_addr_enb,
  input  logic [9:0]          i_h_idx,
  input  logic [9:0]          i_v_idx,
  vga_fb_reader_if.master     fb,
  output logic [DATA_BIT-1:0] o_rgb,
  output logic                o_hsync_n,
  output logic                o_vsync_n
);
  localparam int H_FB     = H_RES >> SCALE_SHIFT;
  localparam int FB_WORDS = H_FB * (V_RES >> SCALE_SHIFT);

  if (RD_LATENCY < 1 || RD_LATENCY >= PX_PERIOD) begin : g_bad_latency
    $error("vga_fb_reader: RD_LATENCY must lie in 1..PX_PERIOD-1");
  end
  if (FB_WORDS > (1 << ADDR_BIT)) begin : g_bad_addr_bit
    $error("vga_fb_reader: ADDR_BIT too narrow for the framebuffer");
  end

  logic                  act_s;
  logic [31:0]           addr_full_s;
  logic [DATA_BIT-1:0]   pix_s;
  logic                  hs0_r;
  logic                  vs0_r;
  logic                  act0_r;
  logic                  rd_en_r;
  logic [ADDR_BIT-1:0]   rd_addr_r;
  logic [RD_LATENCY-1:0] rd_vld_r;
  logic [DATA_BIT-1:0]   hold_r;

  // Visible-area flag and scaled framebuffer word index for the current coordinate.
  always_comb begin
    act_s       = i_h_addr_enb & i_v_addr_enb;
    addr_full_s = 32'(i_v_idx >> SCALE_SHIFT) * 32'(H_FB)
                + 32'(i_h_idx >> SCALE_SHIFT);
  end

  // When the read lands exactly on the display tick, forward it past the hold register.
  always_comb begin
    if (rd_vld_r[RD_LATENCY-1]) begin
      pix_s = fb.rd_data;
    end else begin
      pix_s = hold_r;
    end
  end

  // Stage 0: capture sync/area flags and launch a one-cycle read on each pixel tick.
  always_ff @(posedge clk) begin
    if (i_sclr) begin
      hs0_r     <= 1'b0;
      vs0_r     <= 1'b0;
      act0_r    <= 1'b0;
      rd_en_r   <= 1'b0;
      rd_addr_r <= {ADDR_BIT{1'b0}};
    end else if (i_px_clk) begin
      hs0_r   <= i_hsync_enb;
      vs0_r   <= i_vsync_enb;
      act0_r  <= act_s;
      rd_en_r <= act_s;
      if (act_s) begin
        rd_addr_r <= ADDR_BIT'(addr_full_s);
      end
    end else begin
      rd_en_r <= 1'b0;
    end
  end

  // Track the outstanding read and capture the RAM word when it arrives.
  always_ff @(posedge clk) begin
    if (i_sclr) begin
      rd_vld_r <= {RD_LATENCY{1'b0}};
      hold_r   <= {DATA_BIT{1'b0}};
    end else begin
      rd_vld_r <= RD_LATENCY'({rd_vld_r, rd_en_r});
      if (rd_vld_r[RD_LATENCY-1]) begin
        hold_r <= fb.rd_data;
      end
    end
  end

  // Stage 1: drive the pins one tick later so colour and sync stay aligned.
  always_ff @(posedge clk) begin
    if (i_sclr) begin
      o_rgb     <= {DATA_BIT{1'b0}};
      o_hsync_n <= 1'b1;
      o_vsync_n <= 1'b1;
    end else if (i_px_clk) begin
      o_rgb     <= act0_r ? pix_s : {DATA_BIT{1'b0}};
      o_hsync_n <= ~hs0_r;
      o_vsync_n <= ~vs0_r;
    end
  end

  assign fb.rd_addr = rd_addr_r;
  assign fb.rd_en   = rd_en_r;
endmodule
